// File: rtl/div_pkg.sv
// Shared types and constants for the fixed-point divider and its recompose checker.
package div_pkg;
    typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} state_t;

    localparam int DEF_WIDTH = 30;
    localparam int DEF_FRAC  = DEF_WIDTH - 2;
    localparam int DEF_TOL   = 4;

    localparam logic [63:0] ONE = 64'd1 << DEF_FRAC;

    function automatic logic [63:0] one_fx(input int frac);
        return 64'd1 << frac;
    endfunction
endpackage

// File: rtl/div_recompose_if.sv
// Operand/result handshake bundle between a requester and div_recompose.
interface div_recompose_if import div_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] denominator;
    logic [WIDTH-1:0] remainder;
    logic [WIDTH-1:0] numerator;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] recomposed;
    logic [WIDTH:0]   error;
    logic             match;
    logic             overflow;

    modport master (
        output in_valid, quotient, denominator, remainder, numerator, out_ready,
        input  in_ready, out_valid, recomposed, error, match, overflow
    );

    modport slave (
        input  in_valid, quotient, denominator, remainder, numerator, out_ready,
        output in_ready, out_valid, recomposed, error, match, overflow
    );
endinterface

// File: rtl/shift_add_mult.sv
// Radix-2 shift-add multiplier, one multiplier bit per clock; done pulses one cycle after the last step.
module shift_add_mult #(
    parameter int WIDTH = 30
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;
    logic               busy_q;
    logic               done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            count  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start && !busy_q) begin
                mcand  <= {{WIDTH{1'b0}}, multiplicand};
                mplier <= multiplier;
                acc    <= '0;
                count  <= '0;
                busy_q <= 1'b1;
            end else if (busy_q) begin
                if (mplier[0])
                    acc <= acc + (mcand << count);
                mplier <= mplier >> 1;
                count  <= count + CW'(1);
                if (count == CW'(WIDTH - 1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = acc;
endmodule

// File: rtl/div_recompose.sv
// Rebuilds the dividend from a divider's quotient/remainder and compares it to the original numerator.
module div_recompose import div_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = WIDTH - 2,
    parameter int TOL   = DEF_TOL
) (
    input  logic           clk,
    input  logic           reset,
    div_recompose_if.slave bus
);
    localparam int SW = WIDTH + FRAC + 1;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   rem_q, num_q;
    logic               mul_start, mul_busy, mul_done;
    logic [2*WIDTH-1:0] product;

    logic [SW-1:0]      sum;
    logic               ovf;
    logic [WIDTH-1:0]   rec;
    logic [WIDTH:0]     err, err_abs;
    logic               hit;

    logic [WIDTH-1:0]   rec_q;
    logic [WIDTH:0]     err_q;
    logic               match_q, ovf_q;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign mul_start     = bus.in_valid && (state == IDLE);

    shift_add_mult #(.WIDTH(WIDTH)) u_mult (
        .clk          (clk),
        .reset        (reset),
        .start        (mul_start),
        .multiplicand (bus.denominator),
        .multiplier   (bus.quotient),
        .busy         (mul_busy),
        .done         (mul_done),
        .product      (product)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (mul_start)             state_nxt = MUL;
            MUL:  if (mul_done && !mul_busy) state_nxt = ADD;
            ADD:                             state_nxt = DONE;
            DONE: if (bus.out_ready)         state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= '0;
            num_q <= '0;
        end else if (mul_start) begin
            rem_q <= bus.remainder;
            num_q <= bus.numerator;
        end
    end

    // Dropped fractional product bits truncate toward zero; the sum is wide enough to never wrap.
    always_comb begin
        sum     = SW'(product >> FRAC) + SW'(rem_q);
        ovf     = |sum[SW-1:WIDTH];
        rec     = ovf ? '1 : sum[WIDTH-1:0];
        err     = {1'b0, num_q} - {1'b0, rec};
        err_abs = err[WIDTH] ? -err : err;
        hit     = !ovf && (err_abs <= (WIDTH+1)'(TOL));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rec_q   <= '0;
            err_q   <= '0;
            match_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state == ADD) begin
            rec_q   <= rec;
            err_q   <= err;
            match_q <= hit;
            ovf_q   <= ovf;
        end
    end

    assign bus.recomposed = rec_q;
    assign bus.error      = err_q;
    assign bus.match      = match_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_div_recompose.sv
// Directed scoreboard bench for div_recompose at WIDTH=30, FRAC=28, TOL=4.
module tb_div_recompose;
    import div_pkg::*;

    localparam int W = 30;

    typedef struct packed {
        logic [W-1:0] rec;
        logic [W:0]   err;
        logic         match;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    div_recompose_if #(.WIDTH(W)) bus();

    div_recompose #(.WIDTH(W), .FRAC(W-2), .TOL(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", 64'(bus.recomposed), 64'hDEAD);
            end else begin
                e = sb.pop_front();
                chk("recomposed", 64'(bus.recomposed), 64'(e.rec));
                chk("error",      64'(bus.error),      64'(e.err));
                chk("match",      64'(bus.match),      64'(e.match));
                chk("overflow",   64'(bus.overflow),   64'(e.ovf));
            end
        end
    end

    task automatic send(input logic [W-1:0] q, input logic [W-1:0] d, input logic [W-1:0] r,
                        input logic [W-1:0] n, input exp_t e, input bit push);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.quotient    = q;
        bus.denominator = d;
        bus.remainder   = r;
        bus.numerator   = n;
        bus.in_valid    = 1'b1;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("accept_timeout", 64'(guard), 64'd0);
        @(posedge clk);
        if (push) sb.push_back(e);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name);
        int n;
        for (n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) break;
        end
        chk(name, 64'(n), 64'd32);
    endtask

    task automatic job(input string name, input logic [W-1:0] q, input logic [W-1:0] d,
                       input logic [W-1:0] r, input logic [W-1:0] n, input logic [W-1:0] rec,
                       input logic [W:0] err, input logic m, input logic o);
        exp_t e;
        e = '{rec: rec, err: err, match: m, ovf: o};
        send(q, d, r, n, e, 1'b1);
        wait_out({name, "_latency"});
        @(posedge clk);
        #1;
        chk({name, "_in_ready_after"}, 64'(bus.in_ready), 64'd1);
        chk({name, "_valid_dropped"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        exp_t e;
        bus.in_valid    = 1'b0;
        bus.quotient    = '0;
        bus.denominator = '0;
        bus.remainder   = '0;
        bus.numerator   = '0;
        bus.out_ready   = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",   64'(bus.in_ready),   64'd1);
        chk("rst_out_valid",  64'(bus.out_valid),  64'd0);
        chk("rst_recomposed", 64'(bus.recomposed), 64'd0);
        chk("rst_error",      64'(bus.error),      64'd0);
        chk("rst_match",      64'(bus.match),      64'd0);
        chk("rst_overflow",   64'(bus.overflow),   64'd0);
        reset = 1'b0;

        // 0.5 * 1.0
        job("half", 30'h0800_0000, 30'h1000_0000, 30'd0, 30'h0800_0000,
            30'h0800_0000, 31'd0, 1'b1, 1'b0);
        // product term 0x0FFF_FFFF + 3, error -2 within tolerance
        job("tol_in", 30'h0AAA_AAAA, 30'h1800_0000, 30'd3, 30'h1000_0000,
            30'h1000_0002, 31'h7FFF_FFFE, 1'b1, 1'b0);
        // same product, error +5 beyond tolerance
        job("tol_out", 30'h0AAA_AAAA, 30'h1800_0000, 30'd3, 30'h1000_0007,
            30'h1000_0002, 31'd5, 1'b0, 1'b0);
        // 3.0 * 3.0 saturates; zero error but overflow forbids match
        job("ovf", 30'h3000_0000, 30'h3000_0000, 30'd0, 30'h3FFF_FFFF,
            30'h3FFF_FFFF, 31'd0, 1'b0, 1'b1);
        // tiny product truncates to zero
        job("trunc", 30'd1, 30'h0FFF_FFFF, 30'd2, 30'd2,
            30'd2, 31'd0, 1'b1, 1'b0);
        job("den_zero", 30'h1234_5678, 30'd0, 30'h77, 30'h77,
            30'h77, 31'd0, 1'b1, 1'b0);

        // backpressure: 1.0 * 2.0 + 1
        bus.out_ready = 1'b0;
        e = '{rec: 30'h2000_0001, err: 31'd0, match: 1'b1, ovf: 1'b0};
        send(30'h1000_0000, 30'h2000_0000, 30'd1, 30'h2000_0001, e, 1'b1);
        wait_out("bp_latency");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid",  64'(bus.out_valid),  64'd1);
            chk("bp_in_ready",   64'(bus.in_ready),   64'd0);
            chk("bp_recomposed", 64'(bus.recomposed), 64'h2000_0001);
            chk("bp_match",      64'(bus.match),      64'd1);
            bus.quotient    = 30'h3FFF_FFFF;
            bus.denominator = 30'h3FFF_FFFF;
            bus.remainder   = 30'h1;
            bus.numerator   = 30'h0;
            bus.in_valid    = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_in_ready_after",  64'(bus.in_ready),  64'd1);
        chk("bp_valid_dropped",   64'(bus.out_valid), 64'd0);
        // back-to-back: 0.25 * 0.75
        job("b2b", 30'h0400_0000, 30'h0C00_0000, 30'd0, 30'h0300_0000,
            30'h0300_0000, 31'd0, 1'b1, 1'b0);

        // abort mid-multiply
        e = '{rec: 30'd0, err: 31'd0, match: 1'b0, ovf: 1'b0};
        send(30'h1555_5555, 30'h2AAA_AAAA, 30'd9, 30'd9, e, 1'b0);
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("abort_in_ready",   64'(bus.in_ready),   64'd1);
        chk("abort_out_valid",  64'(bus.out_valid),  64'd0);
        chk("abort_recomposed", 64'(bus.recomposed), 64'd0);
        chk("abort_error",      64'(bus.error),      64'd0);
        chk("abort_match",      64'(bus.match),      64'd0);
        chk("abort_overflow",   64'(bus.overflow),   64'd0);
        repeat (40) @(posedge clk);
        job("fresh", 30'd0, 30'h1000_0000, 30'h55, 30'h55,
            30'h55, 31'd0, 1'b1, 1'b0);

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
